// File: rtl/scan_ctrl_pkg.sv
// scan_ctrl_pkg: shared state encoding and limits for the scan chain controller.
package scan_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, CAPTURE, UNLOAD, DONE} state_t;
  localparam int CAP_MAX = 15;
endpackage

// File: rtl/scan_ctrl_cnt.sv
// scan_ctrl_cnt: clearable up-counter that stops at a programmable terminal value.
module scan_ctrl_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic         tc
);
  logic [W-1:0] cnt;
  assign tc = cnt == last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !tc) cnt <= cnt + 1'b1;
endmodule

// File: rtl/scan_ctrl.sv
// scan_ctrl: loads a pattern into a scan chain, pulses capture, unloads the response.
// Optional response compare enabled by defining SCAN_CTRL_COMPARE_EN.
module scan_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN  = 8,
  parameter int CAP_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic                 scan_out,
`ifdef SCAN_CTRL_COMPARE_EN
  input  logic [CHAIN_LEN-1:0] expected,
  output logic                 mismatch,
`endif
  output logic                 scan_en,
  output logic                 scan_in,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] response
);
  localparam int CAP = CAP_CYCLES > CAP_MAX ? CAP_MAX : CAP_CYCLES;
  // wide enough to count either the shift phases or the capture phase
  localparam int WL = $clog2(CHAIN_LEN + 1);
  localparam int WC = $clog2(CAP + 1);
  localparam int W = WL > WC ? WL : WC;
  localparam logic [W-1:0] LEN_LAST = W'(CHAIN_LEN - 1);
  localparam logic [W-1:0] CAP_LAST = W'(CAP - 1);
  state_t state, nxt;
  logic [CHAIN_LEN-1:0] sr;
  logic [CHAIN_LEN:0] shifted;
  logic [W-1:0] last;
  logic tc, clr, en, accept;
  assign scan_in = sr[CHAIN_LEN-1];
  always_comb begin
    accept = state == IDLE && start;
    last = state == CAPTURE ? CAP_LAST : LEN_LAST;
    nxt = state == IDLE ? (start ? LOAD : IDLE) :
          state == LOAD ? (tc ? CAPTURE : LOAD) :
          state == CAPTURE ? (tc ? UNLOAD : CAPTURE) :
          state == UNLOAD ? (tc ? DONE : UNLOAD) : IDLE;
    clr = nxt != state;
    en = state inside {LOAD, CAPTURE, UNLOAD};
    shifted = {response, scan_out};
  end
  scan_ctrl_cnt #(.W(W)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .en   (en),
    .last (last),
    .tc   (tc)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      sr       <= '0;
      response <= '0;
      scan_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state   <= nxt;
      scan_en <= nxt == LOAD || nxt == UNLOAD;
      busy    <= nxt != IDLE;
      done    <= nxt == DONE;
      if (accept) sr <= pattern;
      else if (state == LOAD) sr <= sr << 1;
      if (state == UNLOAD) response <= shifted[CHAIN_LEN-1:0];
    end
`ifdef SCAN_CTRL_COMPARE_EN
  logic [CHAIN_LEN-1:0] exp_r;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      exp_r    <= '0;
      mismatch <= 1'b0;
    end else if (accept) begin
      exp_r    <= expected;
      mismatch <= 1'b0;
    end else if (state == UNLOAD && tc) mismatch <= shifted[CHAIN_LEN-1:0] != exp_r;
`endif
endmodule

// File: tb/tb_scan_ctrl.sv
// tb_scan_ctrl: directed checks of scan_ctrl against an 8-flop chain model.
module tb_scan_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [7:0] pattern = '0, chain = '0, response;
  logic scan_out, scan_en, scan_in, busy, done;
  bit inv = 1'b0;
  int checks = 0, errors = 0;
  int lat, low, nd, first, prev;
`ifdef SCAN_CTRL_COMPARE_EN
  logic [7:0] expected = '0;
  logic mismatch;
`endif

  always #5 clk = ~clk;

  // chain model: shifts when scan_en, otherwise holds or captures inverse
  assign scan_out = chain[7];
  always @(posedge clk) chain <= scan_en ? {chain[6:0], scan_in} : (inv ? ~chain : chain);

  scan_ctrl #(.CHAIN_LEN(8), .CAP_CYCLES(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .pattern (pattern),
    .scan_out(scan_out),
`ifdef SCAN_CTRL_COMPARE_EN
    .expected(expected),
    .mismatch(mismatch),
`endif
    .scan_en (scan_en),
    .scan_in (scan_in),
    .busy    (busy),
    .done    (done),
    .response(response)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // call at a negedge while idle; returns at the negedge where done is seen
  task automatic run(input logic [7:0] pat, output int l, output int lo);
    start = 1'b1;
    pattern = pat;
    @(negedge clk);
    start = 1'b0;
    l = 0;
    lo = 0;
    while (!done && l < 100) begin
      if (busy && !scan_en) lo++;
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    #3;
    chk("rst_scan_en", scan_en, 0);
    chk("rst_scan_in", scan_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_response", response, 0);

    @(negedge clk);
    rst_n = 1'b1;
    run(8'hA5, lat, low);
    chk("loop_latency", lat, 17);
    chk("loop_response", response, 8'hA5);
    chk("loop_capture_cycles", low, 1);
    chk("loop_busy_at_done", busy, 1);
    @(negedge clk);
    chk("loop_done_pulse", done, 0);
    chk("loop_busy_after", busy, 0);

    inv = 1'b1;
    run(8'h0F, lat, low);
    chk("cap_latency", lat, 17);
    chk("cap_response", response, 8'hF0);
    @(negedge clk);
    inv = 1'b0;

    start = 1'b1;
    pattern = 8'h5A;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) nd++;
      start = (i == 2 || i == 12);
    end
    chk("ignore_done_count", nd, 1);
    chk("ignore_response", response, 8'h5A);

    start = 1'b1;
    pattern = 8'hC3;
    nd = 0;
    first = -1;
    prev = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        if (first < 0) first = i;
        else chk("b2b_gap", i - prev, 19);
        prev = i;
        nd++;
      end
    end
    start = 1'b0;
    chk("b2b_first", first, 17);
    chk("b2b_count", nd, 3);
    chk("b2b_response", response, 8'hC3);
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    chk("b2b_drained", busy, 0);

    @(negedge clk);
    start = 1'b1;
    pattern = 8'h96;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("unload_busy", busy, 1);
    chk("unload_scan_en", scan_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_scan_en", scan_en, 0);
    chk("arst_scan_in", scan_in, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_response", response, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(8'h96, lat, low);
    chk("post_rst_latency", lat, 17);
    chk("post_rst_response", response, 8'h96);
    @(negedge clk);

`ifdef SCAN_CTRL_COMPARE_EN
    expected = 8'h3C;
    run(8'h3C, lat, low);
    chk("cmp_eq_response", response, 8'h3C);
    chk("cmp_eq_mismatch", mismatch, 0);
    @(negedge clk);
    expected = 8'h3D;
    run(8'h3C, lat, low);
    chk("cmp_ne_mismatch", mismatch, 1);
    @(negedge clk);
    chk("cmp_ne_held", mismatch, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
